// File: rtl/dnn_pkg.sv
// Shared types and constants for the dnn_opt issue scheduler.
package dnn_pkg;

    typedef enum logic [2:0] {
        WARMUP,
        IDLE,
        B1,
        B2,
        B3
    } sched_state_t;

    localparam int DP_SLOT_CYCLES = 4;
    localparam int WARMUP_CYCLES  = 4;

    // Tag field sized for the largest supported requester count (8).
    localparam int RSP_TAG_W = 3;
    localparam int RSP_OUT_W = 21;

    typedef struct packed {
        logic [RSP_TAG_W-1:0]        tag;
        logic signed [RSP_OUT_W-1:0] out0;
        logic signed [RSP_OUT_W-1:0] out1;
    } rsp_entry_t;

endpackage

// File: rtl/dnn_issue_sched_if.sv
// Requester, response and datapath signals of the issue scheduler.
interface dnn_issue_sched_if #(
    parameter int N_REQ = 2,
    parameter int X_W   = 7,
    parameter int OUT_W = 21
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*4*X_W-1:0] req_x;
    logic [N_REQ-1:0]       rsp_valid;
    logic [N_REQ-1:0]       rsp_ready;
    logic signed [OUT_W-1:0] rsp_out0;
    logic signed [OUT_W-1:0] rsp_out1;
    logic signed [X_W-1:0]   dp_x0;
    logic signed [X_W-1:0]   dp_x1;
    logic signed [X_W-1:0]   dp_x2;
    logic signed [X_W-1:0]   dp_x3;
    logic                    dp_in_ready;
    logic signed [OUT_W-1:0] dp_out0;
    logic signed [OUT_W-1:0] dp_out1;
    logic                    dp_out0_ready;
    logic                    dp_out1_ready;
    logic                    busy;
    logic                    err_spurious;

    // Requesters plus datapath (environment side).
    modport master (
        output req_valid, req_x, rsp_ready,
        output dp_out0, dp_out1, dp_out0_ready, dp_out1_ready,
        input  req_ready, rsp_valid, rsp_out0, rsp_out1,
        input  dp_x0, dp_x1, dp_x2, dp_x3, dp_in_ready, busy, err_spurious
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_x, rsp_ready,
        input  dp_out0, dp_out1, dp_out0_ready, dp_out1_ready,
        output req_ready, rsp_valid, rsp_out0, rsp_out1,
        output dp_x0, dp_x1, dp_x2, dp_x3, dp_in_ready, busy, err_spurious
    );
endinterface

// File: rtl/dnn_rsp_fifo.sv
// Two-entry response FIFO; push and pop may coincide at any fill level.
module dnn_rsp_fifo
    import dnn_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  rsp_entry_t push_data_i,
    input  logic       pop_i,
    output rsp_entry_t head_o,
    output logic [1:0] cnt_o
);
    rsp_entry_t mem_q [2];
    logic       wr_q;
    logic       rd_q;
    logic [1:0] cnt_q;

    // Storage, pointers and fill count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= ~wr_q;
            end
            if (pop_i) rd_q <= ~rd_q;
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head_o = mem_q[rd_q];
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/dnn_issue_sched.sv
// Round-robin issue scheduler sharing one dnn_opt datapath between requesters.
//   state  | meaning
//   WARMUP | datapath settling after reset, no issue
//   IDLE   | check returning result, issue next job if eligible
//   B1..B3 | job in flight, no issue, no result expected
module dnn_issue_sched
    import dnn_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    parameter int X_W   = 7,
    parameter int OUT_W = RSP_OUT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    dnn_issue_sched_if.slave   bus
);
    sched_state_t     state_q, state_d;
    logic [2:0]       warm_cnt_q, warm_cnt_d;
    logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;

    logic             grant_found;
    logic [TAG_W-1:0] grant_idx;
    logic             issue;
    logic             push;
    logic             pop;
    logic             fifo_nonempty;
    logic [1:0]       fifo_cnt;
    rsp_entry_t       head;
    rsp_entry_t       push_data;
    logic [4*X_W-1:0] x_sel;

    wire strobe_any  = bus.dp_out0_ready | bus.dp_out1_ready;
    wire strobe_both = bus.dp_out0_ready & bus.dp_out1_ready;

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!grant_found && bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = TAG_W'(idx);
            end
        end
    end

    // Slot sequencing, result checking and issue decision.
    always_comb begin
        logic arriving;
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        tag_d      = tag_q;
        pend_d     = pend_q;
        err_d      = err_q;
        push       = 1'b0;
        issue      = 1'b0;
        arriving   = 1'b0;
        case (state_q)
            WARMUP: begin
                if (warm_cnt_q == 3'(WARMUP_CYCLES - 1)) state_d = IDLE;
                else                                     warm_cnt_d = warm_cnt_q + 3'd1;
            end
            IDLE: begin
                // A pending job's result must land in this exact cycle; otherwise it is lost.
                if (pend_q) begin
                    if (strobe_both) begin
                        arriving = 1'b1;
                        push     = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    pend_d = 1'b0;
                end else if (strobe_any) begin
                    err_d = 1'b1;
                end
                if (grant_found && (({1'b0, fifo_cnt} + {2'b00, arriving}) < 3'd2)) begin
                    issue   = 1'b1;
                    tag_d   = grant_idx;
                    pend_d  = 1'b1;
                    state_d = B1;
                    if (int'(grant_idx) == N_REQ - 1) rr_ptr_d = '0;
                    else                              rr_ptr_d = grant_idx + 1'b1;
                end
            end
            B1: begin
                if (strobe_any) err_d = 1'b1;
                state_d = B2;
            end
            B2: begin
                if (strobe_any) err_d = 1'b1;
                state_d = B3;
            end
            B3: begin
                if (strobe_any) err_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = WARMUP;
        endcase
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WARMUP;
            warm_cnt_q <= 3'd0;
            rr_ptr_q   <= '0;
            tag_q      <= '0;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            tag_q      <= tag_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
        end
    end

    assign push_data = '{tag: RSP_TAG_W'(tag_q), out0: bus.dp_out0, out1: bus.dp_out1};

    dnn_rsp_fifo u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .cnt_o       (fifo_cnt)
    );

    assign fifo_nonempty = (fifo_cnt != 2'd0);
    assign x_sel         = bus.req_x[int'(grant_idx)*4*X_W +: 4*X_W];

    // Grant, datapath drive and response presentation.
    always_comb begin
        bus.req_ready   = '0;
        bus.dp_in_ready = issue;
        bus.dp_x0       = '0;
        bus.dp_x1       = '0;
        bus.dp_x2       = '0;
        bus.dp_x3       = '0;
        bus.rsp_valid   = '0;
        bus.rsp_out0    = '0;
        bus.rsp_out1    = '0;
        if (issue) begin
            bus.req_ready = N_REQ'(1) << grant_idx;
            bus.dp_x0     = x_sel[0*X_W +: X_W];
            bus.dp_x1     = x_sel[1*X_W +: X_W];
            bus.dp_x2     = x_sel[2*X_W +: X_W];
            bus.dp_x3     = x_sel[3*X_W +: X_W];
        end
        if (fifo_nonempty) begin
            for (int i = 0; i < N_REQ; i++) bus.rsp_valid[i] = (head.tag == RSP_TAG_W'(i));
            bus.rsp_out0 = head.out0;
            bus.rsp_out1 = head.out1;
        end
    end

    assign pop              = fifo_nonempty && ((bus.rsp_valid & bus.rsp_ready) != '0);
    assign bus.busy         = (state_q == B1) || (state_q == B2) || (state_q == B3) || pend_q || fifo_nonempty;
    assign bus.err_spurious = err_q;

endmodule
